// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: access length codes, IO region
// selector default and the arbiter state enum.
package mem_pkg;

  // d_len / mu_len encodings: [1:0] size, [2] zero-extend on load
  localparam logic [2:0] LEN_B        = 3'b000;
  localparam logic [2:0] LEN_H        = 3'b001;
  localparam logic [2:0] LEN_W        = 3'b010;
  localparam int         LEN_UNSIGNED = 2;

  // addr[17:16] value that marks the memory-mapped IO region
  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single memory unit.
// One transaction in flight at a time; round-robin on ties; stores into the
// IO region are held back while the UART buffer is full without blocking fetch.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_len,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mu_valid,
  output logic        mu_wr,
  output logic [31:0] mu_addr,
  output logic [2:0]  mu_len,
  output logic [31:0] mu_wdata,
  input  logic [31:0] mu_rdata,
  input  logic        mu_ready
);

  state_t state, state_nx;
  logic   last_d;
  logic   d_io_stall, d_elig, grant_i, grant_d;

  // Only a store to the IO region waits for UART space; loads there never stall.
  assign d_io_stall = d_wr && (d_addr[17:16] == IO_SEL) && io_buffer_full;
  assign d_elig     = d_valid && !d_io_stall;

  // Tie goes to the side not served last; the two grants are mutually exclusive.
  assign grant_i = i_valid && (!d_elig || last_d);
  assign grant_d = d_elig  && (!i_valid || !last_d);

  assign mu_valid = (state != IDLE);

  // Completion is gated by rdy_in so a frozen cycle cannot finish a transfer.
  assign i_ready = (state == SERVE_I) && mu_ready && rdy_in;
  assign d_ready = (state == SERVE_D) && mu_ready && rdy_in;
  assign i_data  = i_ready ? mu_rdata : '0;
  assign d_rdata = d_ready ? mu_rdata : '0;

  // Next-state: grant from IDLE, return to IDLE on memory completion.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nx = SERVE_I;
        else if (grant_d) state_nx = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (mu_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset wins over the global enable.
  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end

  // Request registers and round-robin flag, loaded only on a grant in IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_d   <= 1'b1;
      mu_wr    <= 1'b0;
      mu_addr  <= '0;
      mu_len   <= '0;
      mu_wdata <= '0;
    end else if (rdy_in && state == IDLE) begin
      if (grant_i) begin
        last_d   <= 1'b0;
        mu_wr    <= 1'b0;
        mu_addr  <= i_addr;
        mu_len   <= LEN_W;
        mu_wdata <= '0;
      end else if (grant_d) begin
        last_d   <= 1'b1;
        mu_wr    <= d_wr;
        mu_addr  <= d_addr;
        mu_len   <= d_len;
        mu_wdata <= d_wdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter IO_SEL, default 2'b11: value of addr[17:16] that marks the memory-mapped IO region.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; all state frozen when low
- io_buffer_full  input  1  UART buffer full
- i_valid  input  1  instruction-fetch request
- i_addr  input  32  fetch address (always word, unsigned-irrelevant)
- i_ready  output  1  one-cycle completion pulse to fetch
- i_data  output  32  fetched word, valid only while i_ready
- d_valid  input  1  data request
- d_wr  input  1  1 write / 0 read
- d_addr  input  32  data address
- d_len  input  3  [2]=unsigned, [1:0]=00 byte / 01 half / 10 word
- d_wdata  input  32  store data
- d_ready  output  1  one-cycle completion pulse to data side
- d_rdata  output  32  load data, valid only while d_ready
- mu_valid  output  1  request to memory unit
- mu_wr, mu_addr[31:0], mu_len[2:0], mu_wdata[31:0]  output  request fields to memory unit
- mu_rdata  input  32  memory unit read data (valid in mu_ready cycle)
- mu_ready  input  1  memory unit one-cycle completion pulse

Function
REQ-003 The block SHALL implement states IDLE, SERVE_I, SERVE_D.
REQ-004 In IDLE, the block SHALL grant one eligible requester per cycle and move to SERVE_I/SERVE_D on the next edge, registering mu_wr/mu_addr/mu_len/mu_wdata from the granted requester.
REQ-005 For I grants, the block SHALL drive mu_wr=0, mu_len=3'b010, mu_wdata=0.
REQ-006 mu_valid SHALL be high exactly when the state is SERVE_I or SERVE_D.
REQ-007 The I side SHALL be eligible when i_valid=1.
REQ-008 The D side SHALL be eligible when d_valid=1, except for a write with d_addr[17:16]==IO_SEL while io_buffer_full=1, which is ineligible and SHALL NOT block an eligible I request.
REQ-009 When both sides are eligible, the block SHALL grant the side not served last (round-robin flag last_d); last_d SHALL update on each grant.
REQ-010 In SERVE_x, on mu_ready=1 the block SHALL assert x_ready combinationally in the same cycle, pass mu_rdata to x_data/x_rdata, and return to IDLE on that edge.
REQ-011 i_ready and d_ready SHALL never be high in the same cycle, and SHALL be 0 outside SERVE_I/SERVE_D respectively.
REQ-012 In SERVE_x, the block SHALL ignore new or changed requests from either side.
REQ-013 Requester rule: a requester SHALL deassert valid on the edge where its ready is high; the block SHALL spend at least one IDLE cycle between consecutive grants.
REQ-014 Latency: grant cycle T (IDLE) gives mu_valid at T+1; the block SHALL add exactly one cycle over memory-unit latency (byte done at T+2, word at T+5).
REQ-015 While rdy_in=0, the block SHALL hold state, registers and outputs; a mu_ready seen with rdy_in=0 SHALL NOT complete a transaction.
REQ-016 When IO_SEL matches on a read, the block SHALL NOT stall on io_buffer_full.

Reset
REQ-017 When rst_in=1 at an edge, the block SHALL go to IDLE with last_d=1 (I wins the first tie), mu_valid=0, all mu_* registers 0, and i_ready=d_ready=0, even mid-transaction; the aborted requester receives no ready.
REQ-018 Reset SHALL take priority over rdy_in.

Structure
REQ-019 A shared package mem_pkg SHALL hold the len encodings (LEN_B, LEN_H, LEN_W, LEN_UNSIGNED bit), the IO_SEL default and the state enum.
REQ-020 The block SHALL have no sub-module; the memory unit SHALL be instantiated beside the block at the top and connected by mu_* wires.

Verification
REQ-021 Bench scenario, lone fetch: i_valid, i_addr=0x100, memory 0x100..0x103=11,22,33,44 -> i_ready 5 cycles after grant, i_data=0x44332211, d_ready never high.
REQ-022 Bench scenario, simultaneous requests after reset (fetch 0x0, lb from 0x20=0x80) -> I served first; D then gets d_rdata=0xFFFFFF80; a second tie is granted to I only after D (alternation holds).
REQ-023 Bench scenario, IO stall: sb to 0x30000 with io_buffer_full=1 for 10 cycles plus a pending fetch -> fetch completes; no mu_wr=1 to 0x30000 until full drops; the store then completes once.
REQ-024 Bench scenario, rdy_in low 3 cycles mid-word-read -> completion delayed 3 cycles; data unchanged.
REQ-025 Bench scenario, rst_in pulse during SERVE_D word store -> mu_valid=0 the next cycle; no d_ready; the next request is served normally.
REQ-026 Bench scenario, back-to-back sw 0x12345678 @0x40 then lhu @0x42 -> d_rdata=0x00001234.
